// File: rtl/ram_sdp_pipe_pkg.sv
// ram_sdp_pipe_pkg: shared types, defaults and parity helper for ram_sdp_pipe.
package ram_sdp_pipe_pkg;
  typedef enum logic {CLEAR, READY} ram_state_e;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int MAX_RD_LATENCY = 3;
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/ram_sdp_pipe_if.sv
// ram_sdp_pipe_if: write/read request bus and read response signals of ram_sdp_pipe.
interface ram_sdp_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                    write_enb;
  logic [ADDR_WIDTH-1:0]   wr_address;
  logic [DATA_WIDTH-1:0]   data_in;
  logic [DATA_WIDTH/8-1:0] byte_enb;
  logic                    read_enb;
  logic [ADDR_WIDTH-1:0]   rd_address;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    rd_valid;
  logic                    ready;
  logic                    rd_parity_err;
  modport master (
    output write_enb, wr_address, data_in, byte_enb, read_enb, rd_address,
    input  data_out, rd_valid, ready, rd_parity_err
  );
  modport slave (
    input  write_enb, wr_address, data_in, byte_enb, read_enb, rd_address,
    output data_out, rd_valid, ready, rd_parity_err
  );
  modport mon (
    input write_enb, wr_address, data_in, byte_enb, read_enb, rd_address,
    input data_out, rd_valid, ready, rd_parity_err
  );
endinterface

// File: rtl/ram_sdp_pipe_rd_pipe.sv
// ram_sdp_pipe_rd_pipe: LAT-deep {valid, data, parity_err} read pipeline with synchronous active-low flush.
module ram_sdp_pipe_rd_pipe #(
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         err_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         err_o
);
  logic [LAT-1:0] v_q, e_q;
  logic [W-1:0]   d_q [LAT];
  // data stages load only on valid so the output word holds between reads
  always_ff @(posedge clk)
    if (!reset) begin
      v_q <= '0;
      e_q <= '0;
      for (int k = 0; k < LAT; k++) d_q[k] <= '0;
    end else begin
      v_q[0] <= valid_i;
      e_q[0] <= valid_i & err_i;
      if (valid_i) d_q[0] <= data_i;
      for (int k = 1; k < LAT; k++) begin
        v_q[k] <= v_q[k-1];
        e_q[k] <= e_q[k-1];
        if (v_q[k-1]) d_q[k] <= d_q[k-1];
      end
    end
  assign valid_o = v_q[LAT-1];
  assign err_o   = e_q[LAT-1];
  assign data_o  = d_q[LAT-1];
endmodule

// File: rtl/ram_sdp_pipe.sv
// ram_sdp_pipe: simple-dual-port byte-enabled RAM with post-reset clear and pipelined reads.
// Optional per-byte even parity storage and checking when RAM_PARITY_EN is defined.
module ram_sdp_pipe
  import ram_sdp_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input logic clk,
  input logic reset,
  ram_sdp_pipe_if.slave bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] wr_mask, wr_word, rd_word;
  logic                  ready, wr_en, rd_en, same, rd_err;
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  always_comb begin
    state_d = (state_q == CLEAR && &clr_q) ? READY : state_q;
    clr_d   = (state_q == CLEAR) ? clr_q + ADDR_WIDTH'(1) : clr_q;
  end
  assign ready = state_q == READY;
  assign wr_en = ready & reset & bus.write_enb;
  assign rd_en = ready & reset & bus.read_enb;
  assign same  = wr_en && bus.wr_address == bus.rd_address;
  for (genvar i = 0; i < NB; i++) begin : g_mask
    assign wr_mask[8*i+:8] = {8{bus.byte_enb[i]}};
  end
  // write-first: a same-address read sees the merged word
  assign wr_word = (mem_q[bus.wr_address] & ~wr_mask) | (bus.data_in & wr_mask);
  assign rd_word = same ? wr_word : mem_q[bus.rd_address];
  always_ff @(posedge clk)
    if (state_q == CLEAR) mem_q[clr_q] <= '0;
    else if (wr_en) mem_q[bus.wr_address] <= wr_word;
`ifdef RAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] din_par, rd_calc, wr_par, rd_par;
  for (genvar i = 0; i < NB; i++) begin : g_par
    assign din_par[i] = byte_parity(bus.data_in[8*i+:8]);
    assign rd_calc[i] = byte_parity(rd_word[8*i+:8]);
  end
  assign wr_par = (par_q[bus.wr_address] & ~bus.byte_enb) | (din_par & bus.byte_enb);
  assign rd_par = same ? wr_par : par_q[bus.rd_address];
  assign rd_err = |(rd_par ^ rd_calc);
  always_ff @(posedge clk)
    if (state_q == CLEAR) par_q[clr_q] <= '0;
    else if (wr_en) par_q[bus.wr_address] <= wr_par;
`else
  assign rd_err = 1'b0;
`endif
  assign bus.ready = ready;
  ram_sdp_pipe_rd_pipe #(.W(DATA_WIDTH), .LAT(RD_LATENCY)) u_rd_pipe (
    .clk    (clk),
    .reset  (reset),
    .valid_i(rd_en),
    .data_i (rd_word),
    .err_i  (rd_err),
    .valid_o(bus.rd_valid),
    .data_o (bus.data_out),
    .err_o  (bus.rd_parity_err)
  );
endmodule

// File: tb/tb_ram_sdp_pipe.sv
// tb_ram_sdp_pipe: directed table-driven bench for ram_sdp_pipe (DATA_WIDTH=32, ADDR_WIDTH=4, RD_LATENCY=2).
module tb_ram_sdp_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  ram_sdp_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();
  ram_sdp_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] din;
    logic [3:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic        ev;
    logic [31:0] ed;
  } vec_t;
  vec_t tv [25];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] din,
                       input logic [3:0] be, input logic re, input logic [3:0] ra);
    bus.write_enb  = we;
    bus.wr_address = wa;
    bus.data_in    = din;
    bus.byte_enb   = be;
    bus.read_enb   = re;
    bus.rd_address = ra;
  endtask
  task automatic wait_ready(input string name);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!bus.ready && n < 40) begin
      tick();
      n++;
      seen |= bus.rd_valid;
    end
    chk({name, "_clear_cycles"}, 64'(n), 64'd16);
    chk({name, "_clear_no_valid"}, 64'(seen), 64'd0);
  endtask
  task automatic read_one(input string name, input logic [3:0] a, input logic [31:0] exp);
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, a);
    tick();
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
    tick();
    chk({name, "_valid"}, 64'(bus.rd_valid), 64'd1);
    chk({name, "_data"}, 64'(bus.data_out), 64'(exp));
  endtask
  initial begin
    tv[0]  = '{1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3, 1'b0, 32'h0};
    tv[2]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b1, 32'hDEADBEEF};
    tv[3]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b0, 32'hDEADBEEF};
    tv[4]  = '{1'b1, 4'd5, 32'h11223344, 4'hF, 1'b0, 4'd0, 1'b0, 32'hDEADBEEF};
    tv[5]  = '{1'b1, 4'd5, 32'hAABBCCDD, 4'h5, 1'b1, 4'd5, 1'b0, 32'hDEADBEEF};
    tv[6]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b1, 32'h11BB33DD};
    tv[7]  = '{1'b1, 4'd1, 32'h1,        4'hF, 1'b0, 4'd0, 1'b0, 32'h11BB33DD};
    tv[8]  = '{1'b1, 4'd2, 32'h2,        4'hF, 1'b0, 4'd0, 1'b0, 32'h11BB33DD};
    tv[9]  = '{1'b1, 4'd3, 32'h3,        4'hF, 1'b0, 4'd0, 1'b0, 32'h11BB33DD};
    tv[10] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd0, 1'b0, 32'h11BB33DD};
    tv[11] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd1, 1'b1, 32'h0};
    tv[12] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd2, 1'b1, 32'h1};
    tv[13] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3, 1'b1, 32'h2};
    tv[14] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b1, 32'h3};
    tv[15] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b0, 32'h3};
    tv[16] = '{1'b1, 4'd1, 32'hFFFFFFFF, 4'h0, 1'b0, 4'd0, 1'b0, 32'h3};
    tv[17] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd1, 1'b0, 32'h3};
    tv[18] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b1, 32'h1};
    tv[19] = '{1'b1, 4'd9, 32'hCAFEF00D, 4'hF, 1'b1, 4'd2, 1'b0, 32'h1};
    tv[20] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd9, 1'b1, 32'h2};
    tv[21] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b1, 32'hCAFEF00D};
    tv[22] = '{1'b1, 4'd9, 32'h12000000, 4'h8, 1'b0, 4'd0, 1'b0, 32'hCAFEF00D};
    tv[23] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd9, 1'b0, 32'hCAFEF00D};
    tv[24] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b1, 32'h12FEF00D};
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("rst_data_out", 64'(bus.data_out), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_parity_err", 64'(bus.rd_parity_err), 64'd0);
    reset = 1'b1;
    drive(1'b1, 4'd15, 32'hFFFFFFFF, 4'hF, 1'b1, 4'd15);
    wait_ready("init");
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
    tick();
    chk("drop_at_ready_valid", 64'(bus.rd_valid), 64'd0);
    tick();
    chk("drop_at_ready_valid2", 64'(bus.rd_valid), 64'd0);
    for (int a = 0; a < 16; a++) read_one($sformatf("cleared_a%0d", a), 4'(a), 32'h0);
    for (int i = 0; i < 25; i++) begin
      drive(tv[i].we, tv[i].wa, tv[i].din, tv[i].be, tv[i].re, tv[i].ra);
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(bus.rd_valid), 64'(tv[i].ev));
      chk($sformatf("vec%0d_data", i), 64'(bus.data_out), 64'(tv[i].ed));
    end
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3);
    tick();
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
    reset = 1'b0;
    tick();
    chk("midrst_valid", 64'(bus.rd_valid), 64'd0);
    chk("midrst_data", 64'(bus.data_out), 64'd0);
    chk("midrst_ready", 64'(bus.ready), 64'd0);
    tick();
    chk("midrst_valid2", 64'(bus.rd_valid), 64'd0);
    reset = 1'b1;
    drive(1'b1, 4'd3, 32'hA5A5A5A5, 4'hF, 1'b1, 4'd3);
    wait_ready("reclear");
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
    tick();
    chk("reclear_drop_valid", 64'(bus.rd_valid), 64'd0);
    read_one("reclear_a3", 4'd3, 32'h0);
    read_one("reclear_a9", 4'd9, 32'h0);
    chk("clean_parity_err", 64'(bus.rd_parity_err), 64'd0);
`ifdef RAM_PARITY_EN
    drive(1'b1, 4'd7, 32'h01020304, 4'hF, 1'b0, 4'd0);
    tick();
    drive(1'b1, 4'd8, 32'h01020304, 4'hF, 1'b0, 4'd0);
    tick();
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
    dut.mem_q[7][0] = ~dut.mem_q[7][0];
    read_one("par_a7", 4'd7, 32'h01020305);
    chk("par_a7_err", 64'(bus.rd_parity_err), 64'd1);
    read_one("par_a8", 4'd8, 32'h01020304);
    chk("par_a8_err", 64'(bus.rd_parity_err), 64'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_sdp_pipe.md
Name: ram_sdp_pipe

Overview:
Parametrised simple-dual-port synchronous RAM, successor to the single-port RAM.
- One write port and one independent read port on the same clock.
- Per-byte write enables and a configurable read pipeline depth with a read-valid strobe.
- Hardware clear sequencer zeroes the array after reset.
- Drop-in storage for the verification environment and later datapath blocks; the bench drives it through a ram interface with DRV/MON/REF_SB modports.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words
RD_LATENCY, 1, cycles from read_enb sample to data_out/rd_valid; legal 1..3

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-low reset
write_enb  input  1  write request
wr_address  input  ADDR_WIDTH  write word address
data_in  input  DATA_WIDTH  write data
byte_enb  input  DATA_WIDTH/8  per-byte write mask; bit i covers data_in[8i+7:8i]
read_enb  input  1  read request
rd_address  input  ADDR_WIDTH  read word address
data_out  output  DATA_WIDTH  read data, registered
rd_valid  output  1  one-cycle strobe qualifying data_out
ready  output  1  high when the clear sequence is done and requests are accepted
rd_parity_err  output  1  parity error on the current data_out (see Optional Feature)

Behaviour:
- Reset (reset==0 at a posedge):
  - data_out=0, rd_valid=0, ready=0, rd_parity_err=0.
  - Read pipeline flushed.
  - FSM goes to CLEAR and clear counter = 0.
- FSM states:
  - CLEAR: each cycle writes all-zero (with correct parity) to address = counter, then increments the counter. When counter==DEPTH-1 is written, go to READY. Clear takes exactly DEPTH cycles after reset deasserts.
  - READY: ready=1. Only a new reset leaves READY.
- While ready==0:
  - write_enb and read_enb are ignored; no write, no rd_valid.
  - Requests are dropped, not queued.
- Write (READY, write_enb==1 at posedge):
  - For each i with byte_enb[i]==1, mem[wr_address] byte i <= data_in byte i.
  - Other bytes are unchanged.
  - byte_enb==0 is a legal no-op.
- Read (READY, read_enb==1 sampled at posedge N):
  - data_out holds the word and rd_valid==1 after posedge N+RD_LATENCY-1, i.e. visible in cycle N+RD_LATENCY.
  - rd_valid is high for exactly one cycle per accepted read.
  - Back-to-back reads every cycle are supported at full throughput.
  - data_out holds its last value when rd_valid==0.
- Read and write to the same address in the same cycle (write-first): the read returns the merged word, i.e. new bytes where byte_enb=1 and old bytes elsewhere.
- Read and write to different addresses: fully independent.
- Address range: addresses wrap naturally within ADDR_WIDTH; no out-of-range condition exists.
- Reset mid-operation:
  - In-flight reads are discarded and no rd_valid is issued.
  - Memory is re-cleared by the CLEAR sequence.

Optional Feature:
Macro: RAM_PARITY_EN
- Defined:
  - Each byte stores an even-parity bit, computed on every write and clear.
  - On read, parity is checked and rd_parity_err is asserted aligned with rd_valid if any byte mismatches.
  - data_out is returned unmodified.
- Not defined:
  - No parity storage.
  - rd_parity_err is tied to 0.
  - The port list is identical in both builds.

Decomposition:
- ram_pkg gains:
  - typedef ram_state_e {CLEAR, READY}
  - localparams DEFAULT_DATA_WIDTH, DEFAULT_ADDR_WIDTH, MAX_RD_LATENCY=3
  - function byte_parity()
- The transaction class gains byte_enb and rd_valid fields.
- Sub-module ram_rd_pipe holds the RD_LATENCY-deep shift register of {valid, data, parity_err} with synchronous flush.

Test Plan:
- Reset low 2 cycles then high, DATA_WIDTH=32, ADDR_WIDTH=4 -> ready rises exactly 16 cycles after reset deasserts; every address then reads 0x00000000.
- Write 0xDEADBEEF at address 3 with byte_enb=4'hF, then read address 3, RD_LATENCY=2 -> data_out=0xDEADBEEF with rd_valid high 2 cycles after read_enb sampled, for one cycle.
- Preload 0x11223344 at address 5; write 0xAABBCCDD with byte_enb=4'b0101 and read address 5 in the same cycle -> data_out=0x11BB33DD.
- read_enb held high for 4 cycles over addresses 0..3 holding 0,1,2,3 -> rd_valid high for 4 consecutive cycles, data_out=0,1,2,3 in order.
- Issue a read, then assert reset before rd_valid is due -> no rd_valid pulse; ready low for 16 cycles; requests during CLEAR produce no writes and no rd_valid.
- RAM_PARITY_EN defined: bench forces one stored bit flip at address 7 via hierarchical deposit, then reads address 7 -> rd_parity_err=1 aligned with rd_valid; a clean address gives rd_parity_err=0.
